// File: rtl/cmp_pkg.sv
// Shared encodings for the iterative magnitude comparator.
package cmp_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result codes packed as {eq, less, greater}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  // Map a single chunk comparison onto a result code
  function automatic logic [2:0] result_code(input logic is_eq, input logic is_lt);
    if (is_eq) begin
      return RES_EQ;
    end else if (is_lt) begin
      return RES_LT;
    end else begin
      return RES_GT;
    end
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
// Generalised form of the original 2-bit comparator.
module chunk_cmp #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (x == y);
  assign lt = (x <  y);
  assign gt = (x >  y);

endmodule

// File: rtl/iter_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle,
// MSB chunk first, exiting at the first differing chunk.
//
// state | meaning
// IDLE  | waiting for start
// CMP   | comparing chunk idx of the captured operands
// DONE  | result registered, done pulse, may accept a new start
module iter_mag_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 2,
  localparam int NCHUNK = WIDTH / CHUNK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        signed_mode,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic                        busy,
  output logic                        done,
  output logic                        eq,
  output logic                        less,
  output logic                        greater,
  output logic [$clog2(NCHUNK+1)-1:0] cycles
);

  localparam int CW = $clog2(NCHUNK + 1);
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             capture;
  logic             advance;
  logic             finish;
  logic             last;
  logic             c_eq;
  logic             c_lt;
  logic             c_gt;

  // The operand registers shift left as chunks are consumed, so the chunk
  // under test is always the top CHUNK bits; this is equivalent to selecting
  // bits [WIDTH-1-idx*CHUNK -: CHUNK] of the captured values.
  chunk_cmp #(.CHUNK(CHUNK)) u_chunk (
    .x  (a_q[WIDTH-1 -: CHUNK]),
    .y  (b_q[WIDTH-1 -: CHUNK]),
    .eq (c_eq),
    .lt (c_lt),
    .gt (c_gt)
  );

  assign last = (idx == IW'(NCHUNK - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (!c_eq || last) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = CMP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture (offset-binary in signed mode) and chunk stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
    end else if (capture) begin
      a_q <= a ^ (signed_mode ? SIGN_BIT : '0);
      b_q <= b ^ (signed_mode ? SIGN_BIT : '0);
      idx <= '0;
    end else if (advance) begin
      a_q <= a_q << CHUNK;
      b_q <= b_q << CHUNK;
      idx <= idx + IW'(1);
    end
  end

  // Result registers, updated only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {eq, less, greater} <= RES_NONE;
      cycles              <= '0;
    end else if (finish) begin
      {eq, less, greater} <= result_code(c_eq, c_lt);
      cycles              <= CW'(idx) + CW'(1);
    end
  end

  assign busy = (state == CMP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_iter_mag_comparator.sv
// Self-checking bench for iter_mag_comparator (WIDTH=16, CHUNK=2).
module tb_iter_mag_comparator;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic             eq;
  logic             less;
  logic             greater;
  logic [CW-1:0]    cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .eq          (eq),
    .less        (less),
    .greater     (greater),
    .cycles      (cycles)
  );

  // Reference: arithmetic compare, chunks examined = leading equal chunks + 1
  function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic sm, output logic [2:0] flags, output int n);
    logic             lt;
    logic [WIDTH-1:0] d;
    int               p;
    lt = sm ? ($signed(x) < $signed(y)) : (x < y);
    flags = (x == y) ? 3'b100 : (lt ? 3'b010 : 3'b001);
    d = x ^ y;
    p = -1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) p = i;
    n = (p < 0) ? NCHUNK : (WIDTH - 1 - p) / CHUNK + 1;
  endfunction

  // Issue one request starting at a negedge; returns at the negedge of the done cycle.
  task automatic run_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sm,
                         input bit disturb, output logic [2:0] flags, output int ncyc,
                         output int lat, output int busy_bad);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    busy_bad = 0;
    lat = 0;
    @(posedge clk);
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (done) break;
      if (!busy) busy_bad++;
      if (disturb && (lat == 2 || lat == 3)) begin
        start = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = ~sm;
      end
      if (disturb && lat == 4) start = 1'b0;
    end
    if (done && busy) busy_bad++;
    flags = {eq, less, greater};
    ncyc  = int'(cycles);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, eq, less, greater} !== 5'b0 || cycles !== '0) begin
      errors++;
      $display("FAIL reset_state: busy/done/eq/less/greater=%b cycles=%0d, required 00000 and 0",
               {busy, done, eq, less, greater}, cycles);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, eq, less, greater} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy/done/flags=%b, required 00000",
               {busy, done, eq, less, greater});
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ta [5] = '{16'h8000, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h00F0};
    logic [WIDTH-1:0] tb [5] = '{16'h7FFF, 16'h1234, 16'h0001, 16'h0001, 16'h00F1};
    logic             ts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]       tf [5] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b010};
    int               tn [5] = '{1, 8, 1, 1, 8};
    logic [2:0] flags;
    int ncyc, lat, bb;
    for (int i = 0; i < 5; i++) begin
      run_cmp(ta[i], tb[i], ts[i], 1'b0, flags, ncyc, lat, bb);
      checks++;
      if (flags !== tf[i]) begin
        errors++;
        $display("FAIL directed%0d_flags: got %b, required %b", i, flags, tf[i]);
      end
      checks++;
      if (ncyc != tn[i]) begin
        errors++;
        $display("FAIL directed%0d_cycles: got %0d, required %0d", i, ncyc, tn[i]);
      end
      checks++;
      if (lat != tn[i] + 1 || bb != 0) begin
        errors++;
        $display("FAIL directed%0d_timing: done in cycle %0d busy_errs %0d, required cycle %0d busy_errs 0",
                 i, lat, bb, tn[i] + 1);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {eq, less, greater} !== tf[i]) begin
        errors++;
        $display("FAIL directed%0d_hold: done=%b busy=%b flags=%b, required 0 0 %b",
                 i, done, busy, {eq, less, greater}, tf[i]);
      end
    end
  endtask

  task automatic test_handshake();
    logic [WIDTH-1:0] ha [2] = '{16'h1234, 16'h00F0};
    logic [WIDTH-1:0] hb [2] = '{16'h1234, 16'h00F1};
    logic [2:0] flags, ef;
    int ncyc, lat, bb, en;
    for (int i = 0; i < 2; i++) begin
      model(ha[i], hb[i], 1'b0, ef, en);
      run_cmp(ha[i], hb[i], 1'b0, 1'b1, flags, ncyc, lat, bb);
      checks++;
      if (flags !== ef || ncyc != en || lat != en + 1 || bb != 0) begin
        errors++;
        $display("FAIL handshake%0d_disturbed: flags=%b cycles=%0d lat=%0d busy_errs=%0d, required %b %0d %0d 0",
                 i, flags, ncyc, lat, bb, ef, en, en + 1);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL handshake%0d_no_queue: busy=%b done=%b, required 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] x, y;
    logic             sm;
    logic [2:0] flags, ef;
    int ncyc, lat, bb, en;
    for (int i = 0; i < 6; i++) begin
      x  = WIDTH'($urandom);
      y  = (i % 2 == 0) ? WIDTH'($urandom) : x ^ WIDTH'($urandom_range(0, 255));
      sm = 1'($urandom);
      model(x, y, sm, ef, en);
      run_cmp(x, y, sm, 1'b0, flags, ncyc, lat, bb);
      checks++;
      if (flags !== ef || ncyc != en || lat != en + 1 || bb != 0) begin
        errors++;
        $display("FAIL back_to_back%0d: a=%h b=%h s=%b flags=%b cycles=%0d lat=%0d busy_errs=%0d, required %b %0d %0d 0",
                 i, x, y, sm, flags, ncyc, lat, bb, ef, en, en + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] x, y;
    logic             sm;
    logic [2:0] flags, ef;
    int ncyc, lat, bb, en, r;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, WIDTH);
      x  = WIDTH'($urandom);
      y  = (i % 3 == 0) ? WIDTH'($urandom) : x ^ WIDTH'(($urandom) & ((32'd1 << r) - 32'd1));
      sm = 1'($urandom);
      model(x, y, sm, ef, en);
      run_cmp(x, y, sm, 1'b0, flags, ncyc, lat, bb);
      checks++;
      if (flags !== ef || ncyc != en || lat != en + 1 || bb != 0) begin
        errors++;
        $display("FAIL random%0d: a=%h b=%h s=%b flags=%b cycles=%0d lat=%0d busy_errs=%0d, required %b %0d %0d 0",
                 i, x, y, sm, flags, ncyc, lat, bb, ef, en, en + 1);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [2:0] flags;
    int ncyc, lat, bb, seen_done;
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, eq, less, greater} !== 5'b0 || cycles !== '0) begin
      errors++;
      $display("FAIL abort_immediate: busy/done/flags=%b cycles=%0d, required 00000 and 0",
               {busy, done, eq, less, greater}, cycles);
    end
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: activity cycles=%0d, required 0", seen_done);
    end
    run_cmp(16'h0003, 16'h0002, 1'b0, 1'b0, flags, ncyc, lat, bb);
    checks++;
    if (flags !== 3'b001 || ncyc != 8 || lat != 9 || bb != 0) begin
      errors++;
      $display("FAIL abort_recover: flags=%b cycles=%0d lat=%0d busy_errs=%0d, required 001 8 9 0",
               flags, ncyc, lat, bb);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_random();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
